vec_mac_accumulator: RTL and testbench

//  Downstream stage of the SIMD vector-MAC adder tree. Consumes one reduced partial sum per

---
 rtl/vec_mac_accumulator_pkg.sv | 13 +
 rtl/vec_mac_accumulator_out_buf.sv | 40 ++++
 rtl/vec_mac_accumulator.sv | 72 +++++++
 tb/tb_vec_mac_accumulator.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/vec_mac_accumulator_pkg.sv
// simd_vec_mac_pkg: shared types, default widths and saturation helper for the vector-MAC accumulator
package simd_vec_mac_pkg;
  localparam int ELEM_W = 16;
  localparam int NUM_ELEM = 16;
  localparam int DEF_IN_W = ELEM_W + $clog2(NUM_ELEM);
  typedef enum logic {IDLE, ACCUM} acc_state_e;
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] val, input int width);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return val > hi ? hi : val < lo ? lo : val;
  endfunction
endpackage

// File: rtl/vec_mac_accumulator_out_buf.sv
// vec_acc_out_buf: 2-entry valid/ready result FIFO; pushes arriving while full with no pop are dropped
module vec_acc_out_buf #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         drop
);
  logic [W-1:0] mem [2];
  logic         wp, rp, pop, take;
  logic [1:0]   cnt;
  assign valid = cnt != 2'd0;
  assign dout = mem[rp];
  assign pop = valid & ready;
  assign take = push & (cnt != 2'd2 | pop);
  assign drop = push & ~take;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem <= '{default: '0};
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
    end else if (clr) begin
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (take) mem[wp] <= din;
      wp <= wp ^ take;
      rp <= rp ^ pop;
      cnt <= cnt + {1'b0, take} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/vec_mac_accumulator.sv
// vec_mac_accumulator: accumulates N partial sums per dot-product result; VEC_ACC_SAT_EN selects saturating narrowing
module vec_mac_accumulator
  import simd_vec_mac_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = 32,
  parameter int OUT_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sum_valid_i,
  input  logic [IN_W-1:0]  sum_i,
  input  logic [CNT_W-1:0] cfg_chunks_i,
  input  logic             clr_i,
  output logic             acc_valid_o,
  input  logic             acc_ready_i,
  output logic [OUT_W-1:0] acc_o,
  output logic             busy_o,
  output logic             ovf_o,
  output logic             drop_o
);
  acc_state_e              state, state_nx;
  logic [CNT_W-1:0]        cnt, n, n_cfg;
  logic signed [ACC_W-1:0] acc, sum_ext, add_a, add_r;
  logic [OUT_W-1:0]        res;
  logic                    idle, last, ovf_add, buf_drop;
  assign idle = state == IDLE;
  assign n_cfg = cfg_chunks_i == '0 ? CNT_W'(1) : cfg_chunks_i;
  assign sum_ext = {{(ACC_W-IN_W){sum_i[IN_W-1]}}, sum_i};
  assign add_a = idle ? '0 : acc;
  assign add_r = add_a + sum_ext;
  assign ovf_add = ~idle & (acc[ACC_W-1] == sum_ext[ACC_W-1]) & (add_r[ACC_W-1] != acc[ACC_W-1]);
  assign last = sum_valid_i & (idle ? n_cfg == CNT_W'(1) : cnt == n - CNT_W'(1));
  assign busy_o = state == ACCUM;
`ifdef VEC_ACC_SAT_EN
  assign res = OUT_W'(sat_signed(64'(add_r), OUT_W));
`else
  assign res = add_r[OUT_W-1:0];
`endif
  always_comb state_nx = sum_valid_i ? (last ? IDLE : ACCUM) : state;
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      state <= IDLE;
      cnt <= '0;
      n <= '0;
      acc <= '0;
      ovf_o <= 1'b0;
      drop_o <= 1'b0;
    end else begin
      state <= state_nx;
      if (sum_valid_i) begin
        acc <= add_r;
        cnt <= last ? '0 : cnt + CNT_W'(1);
        if (idle) n <= n_cfg;
      end
      ovf_o <= ovf_o | (sum_valid_i & ovf_add);
      drop_o <= drop_o | buf_drop;
    end
  end
  vec_acc_out_buf #(.W(OUT_W)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_i),
    .push  (last & ~clr_i),
    .din   (res),
    .ready (acc_ready_i),
    .valid (acc_valid_o),
    .dout  (acc_o),
    .drop  (buf_drop)
  );
endmodule

// File: tb/tb_vec_mac_accumulator.sv
// tb_vec_mac_accumulator: table vectors, corner sequences and random traffic against a queue-based reference model
module tb_vec_mac_accumulator;
  localparam int IN_W = 31, ACC_W = 32, OUT_W = 24, CNT_W = 8;
`ifdef VEC_ACC_SAT_EN
  localparam longint BIG_EXP = 8388607;
`else
  localparam longint BIG_EXP = 0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, sum_valid = 1'b0, clr = 1'b0, ready = 1'b0;
  logic [IN_W-1:0] sum = '0;
  logic [CNT_W-1:0] cfg = '0;
  logic acc_valid, busy, ovf, drop;
  logic [OUT_W-1:0] acc;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  vec_mac_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .sum_valid_i(sum_valid), .sum_i(sum), .cfg_chunks_i(cfg),
    .clr_i(clr), .acc_valid_o(acc_valid), .acc_ready_i(ready), .acc_o(acc),
    .busy_o(busy), .ovf_o(ovf), .drop_o(drop)
  );
  bit m_busy, m_ovf, m_drop;
  int m_n, m_k;
  longint m_part;
  longint m_q[$];
  function automatic longint wrap32(input longint t);
    logic [31:0] w;
    w = t[31:0];
    return longint'($signed(w));
  endfunction
  function automatic longint narrow(input longint r);
    logic [63:0] t;
`ifdef VEC_ACC_SAT_EN
    return r > 8388607 ? 64'sd8388607 : r < -8388608 ? -64'sd8388608 : r;
`else
    t = r;
    return longint'($signed(t[OUT_W-1:0]));
`endif
  endfunction
  task automatic model_reset();
    m_busy = 0; m_ovf = 0; m_drop = 0; m_n = 0; m_k = 0; m_part = 0;
    m_q.delete();
  endtask
  task automatic model_update(input bit v, input int s, input int c, input bit cl, input bit r);
    bit have;
    longint t;
    have = 0;
    if (cl) begin
      model_reset();
      return;
    end
    if (v) begin
      if (!m_busy) begin
        m_n = c == 0 ? 1 : c;
        m_part = s;
        m_k = 1;
      end else begin
        t = m_part + s;
        if (t > 64'sd2147483647 || t < -64'sd2147483648) m_ovf = 1;
        m_part = wrap32(t);
        m_k++;
      end
      if (m_k == m_n) begin
        have = 1;
        m_busy = 0;
        m_k = 0;
      end else m_busy = 1;
    end
    if (m_q.size() > 0 && r) void'(m_q.pop_front());
    if (have) begin
      if (m_q.size() < 2) m_q.push_back(narrow(m_part));
      else m_drop = 1;
    end
  endtask
  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_all();
    chk("valid", acc_valid, m_q.size() > 0);
    if (m_q.size() > 0) chk("acc", $signed(acc), m_q[0]);
    chk("busy", busy, m_busy);
    chk("ovf", ovf, m_ovf);
    chk("drop", drop, m_drop);
  endtask
  task automatic step(input bit v, input int s, input int c, input bit cl, input bit r);
    sum_valid = v; sum = s[IN_W-1:0]; cfg = c[CNT_W-1:0]; clr = cl; ready = r;
    @(posedge clk);
    model_update(v, s, c, cl, r);
    #1;
    check_all();
  endtask
  typedef struct {
    bit v; int s; int c; bit cl; bit r;
    bit ev; int ea; bit eb;
  } vec_t;
  vec_t tbl[9];
  initial begin
    tbl = '{
      '{1, 10, 4, 0, 1, 0, 0, 1}, '{1, 20, 4, 0, 1, 0, 0, 1}, '{1, -5, 4, 0, 1, 0, 0, 1},
      '{1, 7, 4, 0, 1, 1, 32, 0}, '{0, 0, 4, 0, 1, 0, 0, 0},
      '{1, 3, 1, 0, 1, 1, 3, 0}, '{1, -3, 1, 0, 1, 1, -3, 0}, '{1, 100, 1, 0, 1, 1, 100, 0},
      '{0, 0, 1, 0, 1, 0, 0, 0}
    };
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", acc_valid, 0);
    chk("rst_acc", acc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_drop", drop, 0);
    model_reset();
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].s, tbl[i].c, tbl[i].cl, tbl[i].r);
      chk($sformatf("tbl%0d_valid", i), acc_valid, tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("tbl%0d_acc", i), $signed(acc), tbl[i].ea);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
    end
    for (int k = 1; k <= 4; k++) begin
      step(1, k, 2, 0, 0);
      step(1, k, 2, 0, 0);
    end
    chk("full_head", $signed(acc), 2);
    chk("full_drop", drop, 1);
    step(0, 0, 2, 0, 1);
    chk("pop1_head", $signed(acc), 4);
    step(0, 0, 2, 0, 1);
    chk("pop2_valid", acc_valid, 0);
    chk("drop_sticky", drop, 1);
    step(0, 0, 0, 1, 0);
    step(1, 1, 3, 0, 1);
    step(1, 2, 3, 0, 1);
    step(1, 9, 3, 1, 1);
    chk("clr_busy", busy, 0);
    chk("clr_drop", drop, 0);
    step(1, 5, 3, 0, 1);
    step(1, 5, 3, 0, 1);
    chk("clr_nores", acc_valid, 0);
    step(1, 5, 3, 0, 1);
    chk("clr_res", $signed(acc), 15);
    for (int k = 0; k < 3; k++) step(1, 1073741823, 3, 0, 1);
    chk("ovf_set", ovf, 1);
    repeat (4) step(0, 0, 0, 0, 1);
    chk("ovf_hold", ovf, 1);
    step(0, 0, 0, 1, 1);
    chk("ovf_clr", ovf, 0);
    step(1, 16777216, 1, 0, 1);
    chk("big_acc", $signed(acc), BIG_EXP);
    step(0, 0, 0, 0, 1);
    for (int k = 0; k < 3000; k++) begin
      int s;
      s = ($urandom_range(0, 99) < 10) ? (int'($urandom) >>> 1) : int'($urandom_range(0, 2000)) - 1000;
      step($urandom_range(0, 99) < 70, s, $urandom_range(0, 4), $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 60);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
